sat_updown_counter: RTL

SAT_UPDOWN_COUNTER -- requirements
Module: sat_updown_counter

---
 rtl/sat_updown_counter_pkg.sv | 27 ++
 rtl/sat_addsub.sv | 44 ++++
 rtl/sat_updown_counter.sv | 85 ++++++++
 3 files changed

// File: rtl/sat_updown_counter_pkg.sv
// Shared constants, types and helpers for the saturating up/down counter.
// Holds the default operand width, signed range helpers for an arbitrary
// width, and the decoded per-edge operation type used by the top.

package sat_updown_counter_pkg;

   localparam int DEFAULT_WIDTH = 8;

   // Operation chosen for the coming edge once the input priority is resolved.
   typedef enum logic [1:0] {
      OP_HOLD = 2'd0,
      OP_LOAD = 2'd1,
      OP_ADD  = 2'd2,
      OP_SUB  = 2'd3
   } op_e;

   // Largest value representable in a two's-complement number of 'width' bits.
   function automatic longint signed_max(input int width);
      return (longint'(1) <<< (width - 1)) - longint'(1);
   endfunction

   // Smallest value representable in a two's-complement number of 'width' bits.
   function automatic longint signed_min(input int width);
      return -(longint'(1) <<< (width - 1));
   endfunction

endpackage

// File: rtl/sat_addsub.sv
// Combinational signed add/subtract with overflow detection.
// The sum is formed one bit wider than the operands, so every result
// (including q - (-2^(WIDTH-1))) is exact and overflow is simply the top
// two bits of the wide result disagreeing.
// Build option: define SAT_UPDOWN_COUNTER_SAT_EN to clamp overflowing results
// to the signed limits; leave it undefined to wrap to the low WIDTH bits.

module sat_addsub
   import sat_updown_counter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic signed [WIDTH-1:0] q,
   input  logic signed [WIDTH-1:0] b,
   input  logic                    sub,
   output logic signed [WIDTH-1:0] result,
   output logic                    overflow
);

   localparam logic signed [WIDTH-1:0] MAX_VAL = WIDTH'(signed_max(WIDTH));
   localparam logic signed [WIDTH-1:0] MIN_VAL = WIDTH'(signed_min(WIDTH));

   logic signed [WIDTH:0] q_ext;
   logic signed [WIDTH:0] b_ext;
   logic signed [WIDTH:0] sum;

   // Sign-extend, add or subtract at WIDTH+1 bits, then clamp or wrap the result.
   always_comb begin
      q_ext    = {q[WIDTH-1], q};
      b_ext    = {b[WIDTH-1], b};
      sum      = sub ? (q_ext - b_ext) : (q_ext + b_ext);
      overflow = (sum[WIDTH] != sum[WIDTH-1]);
`ifdef SAT_UPDOWN_COUNTER_SAT_EN
      if (overflow) begin
         result = sum[WIDTH] ? MIN_VAL : MAX_VAL;
      end else begin
         result = sum[WIDTH-1:0];
      end
`else
      result = sum[WIDTH-1:0];
`endif
   end

endmodule

// File: rtl/sat_updown_counter.sv
// Signed up/down counter with load, one-cycle overflow pulse and a sticky
// overflow flag. Reset is synchronous and active-low. The arithmetic and
// the clamp/wrap choice (macro SAT_UPDOWN_COUNTER_SAT_EN) live in sat_addsub;
// this level resolves input priority and owns all registers, so every output
// is registered and there is no combinational path from inputs to outputs.

module sat_updown_counter
   import sat_updown_counter_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int RST_VAL = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   input  logic                    ld,
   input  logic                    up,
   input  logic                    dn,
   input  logic                    clr,
   output logic signed [WIDTH-1:0] q,
   output logic                    ovf,
   output logic                    ovf_sticky
);

   localparam logic signed [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);

   op_e                    op;
   logic                   do_sub;
   logic signed [WIDTH-1:0] step_result;
   logic                   step_ovf;
   logic                   update_ovf;

   // Resolve ld > (up and dn together) > up > dn > hold into one operation.
   always_comb begin
      op = OP_HOLD;
      if (ld) begin
         op = OP_LOAD;
      end else if (up && dn) begin
         op = OP_HOLD;
      end else if (up) begin
         op = OP_ADD;
      end else if (dn) begin
         op = OP_SUB;
      end
   end

   // Overflow only counts when an arithmetic step is actually taken.
   always_comb begin
      do_sub     = (op == OP_SUB);
      update_ovf = ((op == OP_ADD) || (op == OP_SUB)) && step_ovf;
   end

   sat_addsub #(
      .WIDTH (WIDTH)
   ) u_addsub (
      .q        (q),
      .b        (b),
      .sub      (do_sub),
      .result   (step_result),
      .overflow (step_ovf)
   );

   // Count register and overflow flags; a set of the sticky flag beats clr.
   always_ff @(posedge clk) begin
      if (!rst) begin
         q          <= RST_Q;
         ovf        <= 1'b0;
         ovf_sticky <= 1'b0;
      end else begin
         case (op)
            OP_LOAD:         q <= a;
            OP_ADD, OP_SUB:  q <= step_result;
            default:         q <= q;
         endcase
         ovf <= update_ovf;
         if (update_ovf) begin
            ovf_sticky <= 1'b1;
         end else if (clr) begin
            ovf_sticky <= 1'b0;
         end
      end
   end

endmodule
